// File: rtl/tetris_cmd_scheduler_if.sv
// tetris_cmd_scheduler_if: user command strobe plus engine cmd/ready handshake.
interface tetris_cmd_scheduler_if;
  logic       usr_valid;
  logic [2:0] usr_cmd;
  logic       ready;
  logic       cmd_valid;
  logic [2:0] cmd;
  modport master (output usr_valid, usr_cmd, ready, input cmd_valid, cmd);
  modport slave  (input usr_valid, usr_cmd, ready, output cmd_valid, cmd);
endinterface

// File: rtl/tetris_cmd_scheduler.sv
// tetris_cmd_scheduler: queues user commands, generates level-scaled gravity DOWNs, issues one cmd per handshake.
// Optional macro CMD_DEDUP_EN: discard a push equal to the FIFO tail entry (DOWN exempt).
module tetris_cmd_scheduler #(
  parameter int FIFO_DEPTH  = 4,
  parameter int TW          = 25,
  parameter int BASE_PERIOD = 25_000_000,
  parameter int STEP        = 2_000_000,
  parameter int MIN_PERIOD  = 2_500_000
) (
  input  logic                        clk,
  input  logic                        reset_n,
  tetris_cmd_scheduler_if.slave       bus,
  input  logic [3:0]                  i_level,
  input  logic                        i_pause,
  input  logic                        i_game_over,
  output logic                        o_ovf,
  output logic [$clog2(FIFO_DEPTH):0] o_fifo_cnt
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [TW-1:0] BASE_T = TW'(BASE_PERIOD);
  localparam logic [TW-1:0] STEP_T = TW'(STEP);
  localparam logic [TW-1:0] MIN_T  = TW'(MIN_PERIOD);
  localparam logic [TW-1:0] P0     = BASE_T < MIN_T ? MIN_T : BASE_T;
  localparam logic [2:0]    DOWN   = 3'd4;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  state_t        r_state;
  logic [TW-1:0] r_timer, r_period;
  logic          r_grav, r_ovf, r_cmd_valid;
  logic [2:0]    r_cmd;
  logic [2:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [AW:0]   r_cnt;
  logic [TW-1:0] w_dec, w_sub, w_period;
  logic          w_expire, w_go, w_pop, w_req, w_full, w_dup, w_push;
  assign w_dec    = TW'(i_level) * STEP_T;
  assign w_sub    = w_dec >= BASE_T ? '0 : BASE_T - w_dec;
  assign w_period = w_sub < MIN_T ? MIN_T : w_sub;
  assign w_expire = !i_pause && !i_game_over && r_timer == r_period - 1'b1;
  assign w_go     = r_state == IDLE && !i_pause && !i_game_over && (r_grav || r_cnt != '0);
  assign w_pop    = w_go && !r_grav;
  assign w_req    = bus.usr_valid && bus.usr_cmd != 3'd0 && bus.usr_cmd != 3'd7 && !i_game_over;
  assign w_full   = r_cnt == (AW+1)'(FIFO_DEPTH);
`ifdef CMD_DEDUP_EN
  // An entry popped this cycle no longer counts as the tail.
  assign w_dup    = bus.usr_cmd != DOWN && r_cnt > {{AW{1'b0}}, w_pop} && bus.usr_cmd == r_mem[r_wr - 1'b1];
`else
  assign w_dup    = 1'b0;
`endif
  assign w_push   = w_req && !w_dup && (!w_full || w_pop);
  assign o_ovf         = r_ovf;
  assign o_fifo_cnt    = r_cnt;
  assign bus.cmd_valid = r_cmd_valid;
  assign bus.cmd       = r_cmd;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_timer  <= '0;
      r_period <= P0;
      r_grav   <= 1'b0;
    end else if (i_game_over) begin
      r_timer <= '0;
      r_grav  <= 1'b0;
    end else begin
      r_grav <= w_expire || (r_grav && !w_go);
      if (!i_pause) r_timer <= w_expire ? '0 : r_timer + 1'b1;
      if (w_expire) r_period <= w_period;
    end
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wr] <= bus.usr_cmd;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else if (i_game_over) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop) r_rd <= r_rd + 1'b1;
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
      if (w_req && !w_dup && w_full && !w_pop) r_ovf <= 1'b1;
    end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_state     <= IDLE;
      r_cmd_valid <= 1'b0;
      r_cmd       <= '0;
    end else
      case (r_state)
        IDLE: if (w_go) begin
          r_state     <= ISSUE;
          r_cmd_valid <= 1'b1;
          r_cmd       <= r_grav ? DOWN : r_mem[r_rd];
        end
        ISSUE: if (i_game_over || bus.ready) begin
          r_state     <= i_game_over ? IDLE : WAIT;
          r_cmd_valid <= 1'b0;
        end
        WAIT: if (!bus.ready) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
endmodule
